// File: rtl/mult_share_ctrl_pkg.sv
// Shared types and default sizes for the shared-multiplier controller.
// State encodings are fixed so waveforms stay readable across builds.
package mult_share_ctrl_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_IDW   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult.sv
// Plain unsigned combinational array multiplier.
// Operands are zero-extended so the product is computed at full width.
module mult #(
    parameter int width = 4
) (
    input  logic [width-1:0]   a,
    input  logic [width-1:0]   b,
    output logic [2*width-1:0] y
);

    assign y = {{width{1'b0}}, a} * {{width{1'b0}}, b};

endmodule

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Round-robin priority search starting one past the last winner.
// Produces a one-hot grant and the matching binary id.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                id         = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one multiplier between NREQ requesters with round-robin grant.
// Operands and product are registered so the multiplier sits between flops.
module mult_share_ctrl
    import mult_share_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int IDW   = DEF_IDW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_y,
    input  logic                    rsp_ready,
    output logic                    busy
);

    state_t             state;
    state_t             state_nxt;
    logic [IDW-1:0]     last_grant;
    logic [IDW-1:0]     arb_id;
    logic [NREQ-1:0]    arb_grant;
    logic [IDW-1:0]     op_id;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] y;
    logic               can_accept;
    logic               accept;

    rr_arbiter #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_arb (
        .req       (req_valid),
        .last_grant(last_grant),
        .grant     (arb_grant),
        .id        (arb_id)
    );

    mult #(
        .width(WIDTH)
    ) u_mult (
        .a(op_a),
        .b(op_b),
        .y(y)
    );

    // A new request may enter while the previous response is leaving.
    assign can_accept = (state == ST_IDLE) ||
                        (state == ST_DONE && rsp_ready);
    assign req_ready  = can_accept ? arb_grant : '0;
    assign accept     = |req_ready;
    assign busy       = (state == ST_CALC) || (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_CALC;
            end
            ST_CALC: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready) state_nxt = accept ? ST_CALC : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= '0;
            last_grant <= IDW'(NREQ - 1);
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_y      <= '0;
        end else begin
            if (accept) begin
                op_a       <= req_a[arb_id*WIDTH +: WIDTH];
                op_b       <= req_b[arb_id*WIDTH +: WIDTH];
                op_id      <= arb_id;
                last_grant <= arb_id;
            end
            if (state == ST_CALC) begin
                rsp_y     <= y;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end else if (state == ST_DONE && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Randomized and directed checks of mult_share_ctrl against a
// transaction-level reference model, plus a WIDTH=8 corner instance.
module tb_mult_share_ctrl;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk       = 1'b0;
    logic                  rst       = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_a     = '0;
    logic [NREQ*WIDTH-1:0] req_b     = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_y;
    logic                  rsp_ready = 1'b0;
    logic                  busy;

    logic [1:0]  v8 = '0;
    logic [15:0] a8 = '0;
    logic [15:0] b8 = '0;
    logic [1:0]  rdy8;
    logic        rv8;
    logic [0:0]  id8;
    logic [15:0] y8;
    logic        rr8 = 1'b1;
    logic        busy8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_share_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    mult_share_ctrl #(.WIDTH(8), .NREQ(2), .IDW(1)) dut8 (
        .clk(clk), .rst(rst),
        .req_valid(v8), .req_a(a8), .req_b(b8),
        .req_ready(rdy8),
        .rsp_valid(rv8), .rsp_id(id8), .rsp_y(y8),
        .rsp_ready(rr8), .busy(busy8)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one captured job awaiting compute, one held response.
    bit m_cap = 0;  int m_ca = 0;  int m_cb = 0;  int m_cid = 0;
    bit m_rv  = 0;  int m_rid = 0; int m_ry = 0;  int m_last = NREQ - 1;
    bit n_cap = 0;  int n_ca = 0;  int n_cb = 0;  int n_cid = 0;
    bit n_rv  = 0;  int n_rid = 0; int n_ry = 0;  int n_last = NREQ - 1;
    logic [NREQ-1:0] acc_mask = '0;
    logic [NREQ-1:0] eg;
    int win;
    int cyc = 0;
    int log_y[$];
    int log_id[$];
    int log_cyc[$];

    always @(negedge clk) begin
        #2;
        cyc++;
        if (rst) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_valid", rsp_valid, 0);
            chk("rst_id", rsp_id, 0);
            chk("rst_y", rsp_y, 0);
            chk("rst_busy", busy, 0);
            acc_mask = '0;
        end else begin
            eg  = '0;
            win = -1;
            if (!m_cap && (!m_rv || rsp_ready))
                for (int k = 1; k <= NREQ; k++)
                    if (win < 0 && req_valid[(m_last + k) % NREQ])
                        win = (m_last + k) % NREQ;
            if (win >= 0) eg[win] = 1'b1;
            chk("req_ready", req_ready, eg);
            chk("rsp_valid", rsp_valid, m_rv);
            chk("rsp_id", rsp_id, m_rid);
            chk("rsp_y", rsp_y, m_ry);
            chk("busy", busy, m_cap || m_rv);
            n_cap = m_cap; n_ca = m_ca; n_cb = m_cb; n_cid = m_cid;
            n_rv = m_rv; n_rid = m_rid; n_ry = m_ry; n_last = m_last;
            if (m_rv && rsp_ready) begin
                log_y.push_back(m_ry);
                log_id.push_back(m_rid);
                log_cyc.push_back(cyc);
                n_rv = 0;
            end
            if (m_cap) begin
                n_cap = 0;
                n_rv  = 1;
                n_ry  = m_ca * m_cb;
                n_rid = m_cid;
            end
            if (win >= 0) begin
                n_cap  = 1;
                n_ca   = int'(req_a[win*WIDTH +: WIDTH]);
                n_cb   = int'(req_b[win*WIDTH +: WIDTH]);
                n_cid  = win;
                n_last = win;
            end
            acc_mask = eg;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cap <= 0; m_ca <= 0; m_cb <= 0; m_cid <= 0;
            m_rv <= 0; m_rid <= 0; m_ry <= 0; m_last <= NREQ - 1;
        end else begin
            m_cap <= n_cap; m_ca <= n_ca; m_cb <= n_cb; m_cid <= n_cid;
            m_rv <= n_rv; m_rid <= n_rid; m_ry <= n_ry; m_last <= n_last;
        end
    end

    bit keep = 0;

    task automatic set_req(input int i, input int a, input int b);
        req_valid[i] = 1'b1;
        req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
        req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    task automatic tick();
        @(negedge clk);
        if (!keep) req_valid = req_valid & ~acc_mask;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        v8        = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        // single request, max operands
        do_reset();
        rsp_ready = 1'b1;
        base = log_y.size();
        set_req(0, 15, 15);
        #3 chk("t1_grant", req_ready, 4'b0001);
        repeat (5) tick();
        if (log_y.size() > base) begin
            chk("t1_y", log_y[base], 8'hE1);
            chk("t1_id", log_id[base], 0);
        end else chk("t1_count", log_y.size() - base, 1);

        // round robin with all requesters held
        do_reset();
        rsp_ready = 1'b1;
        keep = 1;
        base = log_y.size();
        for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 3);
        repeat (12) tick();
        keep = 0;
        req_valid = '0;
        repeat (4) tick();
        if (log_y.size() - base >= 5) begin
            for (int j = 0; j < 5; j++) begin
                chk("t2_y", log_y[base+j], ((j % 4) + 1) * 3);
                chk("t2_id", log_id[base+j], j % 4);
                if (j > 0)
                    chk("t2_gap", log_cyc[base+j] - log_cyc[base+j-1], 2);
            end
        end else chk("t2_count", log_y.size() - base, 5);

        // backpressure then back-to-back accept in DONE
        do_reset();
        rsp_ready = 1'b0;
        base = log_y.size();
        set_req(1, 7, 9);
        tick();
        set_req(2, 5, 6);
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        chk("t3_valid", rsp_valid, 1);
        repeat (5) begin
            #3;
            chk("t3_hold_y", rsp_y, 8'd63);
            chk("t3_hold_id", rsp_id, 1);
            chk("t3_no_ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        #3 chk("t4_grant", req_ready, 4'b0100);
        @(posedge clk);
        #1 chk("t3_drop", rsp_valid, 0);
        repeat (4) tick();
        if (log_y.size() - base >= 2) begin
            chk("t3_y", log_y[base], 63);
            chk("t4_y", log_y[base+1], 30);
            chk("t4_id", log_id[base+1], 2);
            chk("t4_gap", log_cyc[base+1] - log_cyc[base], 2);
        end else chk("t4_count", log_y.size() - base, 2);

        // reset during CALC
        do_reset();
        rsp_ready = 1'b1;
        set_req(1, 9, 9);
        @(posedge clk);
        #1 chk("t5_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_valid", rsp_valid, 0);
        base = log_y.size();
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        repeat (3) tick();
        chk("t5_stale", log_y.size() - base, 0);
        set_req(0, 2, 2);
        set_req(3, 1, 1);
        #3 chk("t5_grant0", req_ready, 4'b0001);
        repeat (7) tick();

        // boundary operands
        do_reset();
        rsp_ready = 1'b1;
        base = log_y.size();
        set_req(0, 0, 15);
        set_req(1, 15, 1);
        repeat (8) tick();
        if (log_y.size() - base >= 2) begin
            chk("t6_zero", log_y[base], 0);
            chk("t6_id0", log_id[base], 0);
            chk("t6_fifteen", log_y[base+1], 15);
            chk("t6_id1", log_id[base+1], 1);
        end else chk("t6_count", log_y.size() - base, 2);

        // WIDTH=8 instance at maximum operands
        v8 = 2'b01;
        a8[7:0] = 8'd255;
        b8[7:0] = 8'd255;
        n = 0;
        while (!rv8 && n < 10) begin
            tick();
            n++;
        end
        chk("t7_valid8", rv8, 1);
        chk("t7_y8", y8, 16'hFE01);
        chk("t7_id8", id8, 0);
        v8 = '0;

        // randomized traffic with backpressure and dropped requests
        do_reset();
        repeat (3000) begin
            tick();
            rsp_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(2) == 0)
                        set_req(i, int'($urandom_range(15)),
                                int'($urandom_range(15)));
                end else if ($urandom_range(15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Shares one combinational `mult` instance between NREQ requesters.
- Round-robin arbitration selects a requester. The controller captures its operands, registers the product, and returns it tagged with the requester id over a valid/ready response channel.
- Sits between client blocks and the array multiplier. It bounds the multiplier's combinational path between two register stages.

Parameters:
- WIDTH, 4, operand width; passed to the mult instance as `width`.
- NREQ, 4, number of requesters (2..16).
- IDW, 2, requester id width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*WIDTH  operand a; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand b; same packing as req_a.
- req_ready  out  NREQ  one-hot grant/accept; at most one bit high.
- rsp_valid  out  1  result available.
- rsp_id  out  IDW  id of the requester that owns rsp_y.
- rsp_y  out  2*WIDTH  unsigned product a*b.
- rsp_ready  in  1  downstream accepts the response.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; rsp_valid=0; rsp_id=0; rsp_y=0; busy=0; req_ready=0.
  - Operand and id registers are cleared to 0.
  - last_grant=NREQ-1, so requester 0 wins first.
  - Reset mid-transaction discards the in-flight request silently; no response is produced.
- Arbitration (combinational): search req_valid starting at (last_grant+1) mod NREQ, wrapping around; the first set bit wins.
- Handshake: a request transfers on a clock edge where req_valid[i] && req_ready[i].
  - req_ready[i] is high only for the winner, and only when the controller can accept: state==IDLE, or state==DONE && rsp_ready.
  - A requester holds req_valid, req_a and req_b stable until accepted.
  - req_ready must not depend on rsp_valid of other paths; it is only a function of the listed terms.
- FSM:
  - IDLE: on accept, latch a, b and id, set last_grant=id, go to CALC. Otherwise stay.
  - CALC (1 cycle): the mult sees the latched operands; rsp_y<=y; rsp_id<=latched id; rsp_valid<=1; go to DONE.
  - DONE: hold rsp_valid, rsp_y and rsp_id stable while !rsp_ready.
    - On rsp_ready with a pending request: accept the new request in the same edge, rsp_valid<=0, go to CALC.
    - On rsp_ready with no pending request: rsp_valid<=0, go to IDLE.
- Latency: accept edge k → rsp_valid high after edge k+1 → earliest response transfer at edge k+2.
- Throughput: one product per 2 cycles with rsp_ready tied high.
- Arithmetic: unsigned; product width 2*WIDTH; no overflow possible. 0*x=0; max (2**WIDTH-1)**2.
- Simultaneous events:
  - Several req_valid set: the round-robin winner is served; the others wait with req_ready=0.
  - A request arriving in CALC is not accepted until DONE&&rsp_ready.
  - A requester dropping req_valid before acceptance is legal; it is then skipped.
- Operand registers update only on accept; the mult input is never driven directly from req_*.

Decomposition:
- Shared package/include: state encodings (ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2); default WIDTH/NREQ/IDW constants.
- Sub-module: existing `mult` (parameter width=WIDTH), instantiated once.
- Round-robin priority search is natural as a separate `rr_arbiter` (NREQ, IDW). It outputs a one-hot grant plus a binary id, with last_grant as input.

Test Plan:
- Single request: reset, req_valid=4'b0001, a0=15, b0=15 → req_ready=4'b0001 for one cycle; 2 cycles later rsp_valid=1, rsp_y=8'hE1, rsp_id=0.
- Round robin: req_valid=4'b1111 held, rsp_ready=1, operands a_i=i+1, b_i=3 → grant order 0,1,2,3,0; rsp_y sequence 3,6,9,12,3; a new response every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid (a=7, b=9) → rsp_y stays 8'd63, rsp_id stable; req_ready=0 throughout; on rsp_ready=1, rsp_valid drops next cycle.
- Back-to-back in DONE: req2 pending (a=5, b=6) while DONE and rsp_ready rises → req_ready[2]=1 on that same edge; next response rsp_y=30, rsp_id=2, with no idle cycle between.
- Reset mid-op: assert rst during CALC → outputs 0 immediately; after release, no stale rsp_valid; the next grant goes to requester 0.
- Boundary operands: a=0, b=15 → 0; a=15, b=1 → 15; WIDTH=8 build with a=255, b=255 → 16'hFE01.
